// File: rtl/mt_stream_predictor.sv
// mt_stream_predictor: rebuilds MT19937 state from 624 observed words, then
// predicts and checks every later word. Optional build macro: MISMATCH_RESYNC_EN.
// Ports: clk, rst_n (async, low); enable; rng_start/rng_valid/rng_data
// (generator handshake); locked; pred_valid/pred_data; check_valid/mismatch;
// err_cnt (saturating); word_cnt (words collected, 0..624).
module mt_stream_predictor #(
  parameter int ERR_W       = 16,
  parameter int TRACK_LIMIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             rng_start,
  input  logic             rng_valid,
  input  logic [31:0]      rng_data,
  output logic             locked,
  output logic             pred_valid,
  output logic [31:0]      pred_data,
  output logic             check_valid,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [9:0]       word_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_HI, S_UNTEMPER, S_STORE, S_REQ, S_WAIT_LO,
    S_RD0, S_RD1, S_RD2, S_TWIST, S_TEMPER, S_CHECK
  } state_t;

  localparam logic [9:0]  LAST = 10'd623;
  localparam logic [31:0] LIM  = 32'(TRACK_LIMIT);
  localparam logic [31:0] MAG  = 32'h9908B0DF;

  state_t           r_state;
  logic [31:0]      r_y;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_rdata;
  logic [31:0]      r_pred;
  logic [31:0]      r_pcnt;
  logic [9:0]       r_i;
  logic [9:0]       r_wcnt;
  logic             r_locked;
  logic             r_pv;
  logic             r_cv;
  logic             r_mm;
  logic [ERR_W-1:0] r_err;
  logic [31:0]      r_mem [0:623];

  logic [9:0]  w_i1;
  logic [9:0]  w_i397;
  logic [9:0]  w_raddr;
  logic [9:0]  w_waddr;
  logic        w_we;
  logic [31:0] w_wdata;
  logic [31:0] w_mix;
  logic [31:0] w_twist;
  logic        w_miss;
  logic        w_stop;
  logic        w_resync;

  function automatic logic [31:0] f_untemper(input logic [31:0] v);
    logic [31:0] y;
    logic [31:0] t;
    y = v ^ (v >> 18);
    y = y ^ ((y << 15) & 32'hEFC60000);
    t = y;
    for (int k = 0; k < 4; k++)
      t = y ^ ((t << 7) & 32'h9D2C5680);
    y = t;
    y = y ^ (y >> 11) ^ (y >> 22);
    return y;
  endfunction

  function automatic logic [31:0] f_temper(input logic [31:0] v);
    logic [31:0] y;
    y = v ^ (v >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  // index wrap at 624 without a power-of-two mask
  assign w_i1   = (r_i == LAST) ? 10'd0 : r_i + 10'd1;
  assign w_i397 = (r_i >= 10'd227) ? r_i - 10'd227
                                   : r_i + 10'd397;

  assign w_mix   = (r_a & 32'h80000000) | (r_b & 32'h7FFFFFFF);
  assign w_twist = r_rdata ^ (w_mix >> 1) ^ (w_mix[0] ? MAG : 32'd0);

  assign w_miss = (r_y != r_pred);
  assign w_stop = (TRACK_LIMIT != 0) && (r_pcnt == LIM);

`ifdef MISMATCH_RESYNC_EN
  assign w_resync = w_miss;
`else
  assign w_resync = 1'b0;
`endif

  always_comb begin
    w_raddr = r_i;
    unique case (r_state)
      S_RD1:   w_raddr = w_i1;
      S_RD2:   w_raddr = w_i397;
      default: w_raddr = r_i;
    endcase
  end

  assign w_we    = (r_state == S_STORE) || (r_state == S_TWIST);
  assign w_waddr = (r_state == S_STORE) ? r_wcnt : r_i;
  assign w_wdata = (r_state == S_STORE) ? r_y : w_twist;

  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[w_waddr] <= w_wdata;
    r_rdata <= r_mem[w_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_y      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_pred   <= '0;
      r_pcnt   <= '0;
      r_i      <= '0;
      r_wcnt   <= '0;
      r_locked <= 1'b0;
      r_pv     <= 1'b0;
      r_cv     <= 1'b0;
      r_mm     <= 1'b0;
      r_err    <= '0;
    end else begin
      r_pv <= 1'b0;
      r_cv <= 1'b0;
      unique case (r_state)
        // once tracking has ended the block rests here until reset
        S_IDLE:
          if (enable && !r_locked) r_state <= S_WAIT_HI;
        S_WAIT_HI:
          if (enable && rng_valid) begin
            r_y     <= rng_data;
            r_state <= r_locked ? S_CHECK : S_UNTEMPER;
          end
        S_UNTEMPER: begin
          r_y     <= f_untemper(r_y);
          r_state <= S_STORE;
        end
        S_STORE: begin
          r_wcnt <= r_wcnt + 10'd1;
          if (r_wcnt == LAST) begin
            r_locked <= 1'b1;
            r_i      <= '0;
            r_state  <= S_RD0;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_REQ:
          if (enable) r_state <= S_WAIT_LO;
        S_WAIT_LO:
          if (!rng_valid) r_state <= S_WAIT_HI;
        S_RD0:
          r_state <= S_RD1;
        S_RD1: begin
          r_a     <= r_rdata;
          r_state <= S_RD2;
        end
        S_RD2: begin
          r_b     <= r_rdata;
          r_state <= S_TWIST;
        end
        S_TWIST: begin
          r_y     <= w_twist;
          r_state <= S_TEMPER;
        end
        S_TEMPER: begin
          r_pred  <= f_temper(r_y);
          r_pv    <= 1'b1;
          r_pcnt  <= r_pcnt + 32'd1;
          r_state <= S_REQ;
        end
        S_CHECK: begin
          r_cv <= 1'b1;
          r_mm <= w_miss;
          if (w_miss && !(&r_err))
            r_err <= r_err + 1'b1;
          r_i <= w_i1;
          if (w_resync) begin
            r_locked <= 1'b0;
            r_wcnt   <= '0;
            r_state  <= S_REQ;
          end else if (w_stop) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RD0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // combinational so the pulse lives only in REQ and honours enable
  assign rng_start   = (r_state == S_REQ) && enable;
  assign locked      = r_locked;
  assign pred_valid  = r_pv;
  assign pred_data   = r_pred;
  assign check_valid = r_cv;
  assign mismatch    = r_mm;
  assign err_cnt     = r_err;
  assign word_cnt    = r_wcnt;

endmodule

// File: tb/tb_mt_stream_predictor.sv
// tb_mt_stream_predictor: MT19937 source model driving mt_stream_predictor;
// checks predictions, mismatch detection, enable hold and async reset.
module tb_mt_stream_predictor;

  localparam int NW  = 4000;
  localparam int LIM = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        rng_valid = 1'b0;
  logic [31:0] rng_data = '0;
  logic        rng_start;
  logic        locked;
  logic        pred_valid;
  logic [31:0] pred_data;
  logic        check_valid;
  logic        mismatch;
  logic [15:0] err_cnt;
  logic [9:0]  word_cnt;

  mt_stream_predictor #(.ERR_W(16), .TRACK_LIMIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .rng_start(rng_start), .rng_valid(rng_valid), .rng_data(rng_data),
    .locked(locked), .pred_valid(pred_valid), .pred_data(pred_data),
    .check_valid(check_valid), .mismatch(mismatch),
    .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_chk = 0;
  int gi = 0;
  int gdly = 0;
  bit corrupt = 1'b0;
  bit corrupt_word = 1'b0;
  bit pend = 1'b0;
  logic [31:0] outs [NW];
  logic [31:0] st [624];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic build_model();
    logic [31:0] y;
    int idx;
    st[0] = 32'd5489;
    for (int i = 1; i < 624; i++)
      st[i] = 32'd1812433253 * (st[i-1] ^ (st[i-1] >> 30)) + 32'(i);
    idx = 624;
    for (int k = 0; k < NW; k++) begin
      if (idx == 624) begin
        for (int i = 0; i < 624; i++) begin
          y = (st[i] & 32'h80000000) | (st[(i+1)%624] & 32'h7FFFFFFF);
          st[i] = st[(i+397)%624] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'd0);
        end
        idx = 0;
      end
      y = st[idx];
      idx++;
      y = y ^ (y >> 11);
      y = y ^ ((y << 7) & 32'h9D2C5680);
      y = y ^ ((y << 15) & 32'hEFC60000);
      y = y ^ (y >> 18);
      outs[k] = y;
    end
  endtask

  // generator: drops valid after start, delivers the next word 1..3 cycles later
  initial forever begin
    @(negedge clk);
    #1;
    if (rng_start) begin
      rng_valid = 1'b0;
      gdly = 1 + (gi % 3);
      gi++;
      if (gi >= NW - 2) begin
        $display("FAIL gen_words got=%0d exp<%0d", gi, NW - 2);
        $fatal(1);
      end
    end else if (!rng_valid) begin
      if (gdly == 0) begin
        rng_data = outs[gi] ^ {31'd0, corrupt};
        corrupt_word = corrupt;
        corrupt = 1'b0;
        rng_valid = 1'b1;
      end else begin
        gdly--;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (rng_start) n_start++;
      if (pred_valid) begin
        chk("pred", pred_data, outs[gi+1]);
        pend = 1'b1;
      end
      if (check_valid) begin
        chk("order", 32'(pend), 32'd1);
        chk("mism", 32'(mismatch), 32'(corrupt_word));
        pend = 1'b0;
        n_chk++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_wc(input string tag, input int v);
    int t = 0;
    while (word_cnt != 10'(v) && t < LIM) begin tick(); t++; end
    chk(tag, 32'(word_cnt), 32'(v));
  endtask

  task automatic wait_lock(input string tag);
    int t = 0;
    while (!locked && t < LIM) begin tick(); t++; end
    chk(tag, 32'(locked), 32'd1);
  endtask

  task automatic wait_chk(input string tag, input int n);
    int t = 0;
    int tgt;
    tgt = n_chk + n;
    while (n_chk < tgt && t < LIM) begin tick(); t++; end
    chk(tag, 32'(n_chk >= tgt), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"},
        32'({locked, pred_valid, check_valid, mismatch, rng_start}), 32'd0);
    chk({tag, "_wc"}, 32'(word_cnt), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    chk({tag, "_pd"}, pred_data, 32'd0);
  endtask

  initial begin
    int s0;
    int w0;
    int t;
    build_model();
    rng_data = outs[0];
    rng_valid = 1'b1;
    repeat (3) tick();
    chk_zero("rst0");

    rst_n = 1'b1;
    enable = 1'b1;
    s0 = n_start;
    wait_wc("first_wc", 1);
    chk("first_nostart", 32'(n_start - s0), 32'd0);

    wait_wc("wc200", 200);
    enable = 1'b0;
    s0 = n_start;
    repeat (20) tick();
    w0 = int'(word_cnt);
    repeat (3000) tick();
    chk("hold_wc", 32'(word_cnt), 32'(w0));
    chk("hold_start", 32'(n_start - s0), 32'd0);
    enable = 1'b1;

    wait_lock("lock1");
    chk("lock1_wc", 32'(word_cnt), 32'd624);
    chk("lock1_err", 32'(err_cnt), 32'd0);
    wait_chk("run300", 300);
    chk("run_err", 32'(err_cnt), 32'd0);

    corrupt = 1'b1;
    t = 0;
    while (err_cnt == 16'd0 && t < 500) begin tick(); t++; end
    repeat (2) tick();
    chk("err1", 32'(err_cnt), 32'd1);
`ifdef MISMATCH_RESYNC_EN
    chk("lock_drop", 32'(locked), 32'd0);
`else
    chk("lock_keep", 32'(locked), 32'd1);
`endif
    wait_lock("lock2");
    wait_chk("run50", 50);
    chk("err_hold", 32'(err_cnt), 32'd1);

    rst_n = 1'b0;
    #1;
    chk_zero("rstA");
    repeat (2) tick();
    rst_n = 1'b1;
    s0 = n_start;
    wait_wc("firstB_wc", 1);
    chk("firstB_nostart", 32'(n_start - s0), 32'd0);

    wait_wc("wc300", 300);
    rst_n = 1'b0;
    #1;
    chk_zero("rstB");
    repeat (2) tick();
    rst_n = 1'b1;
    wait_lock("lock3");
    chk("lock3_wc", 32'(word_cnt), 32'd624);
    wait_chk("run100", 100);
    chk("end_err", 32'(err_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
